// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises two masters (m0 = SCPU data path, m1 = debug/loader) onto one
// data-RAM port, sequencing enable, write-enable and the fixed RAM read latency.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; when it is undefined,
// m0 has fixed priority on simultaneous requests.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RD_LAT = 1   // 1..4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {StIdle, StAcc, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;      // remaining read-latency cycles, 0..3
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              any_req;
  logic              winner;

  assign any_req = m0_req | m1_req;

`ifdef MEM_ARB_RR_EN
  logic prio_q, prio_d;                 // master favoured on a tie; m0 after reset

  // Winner select: a tie goes to the master not granted last.
  always_comb begin
    winner = (m0_req && m1_req) ? prio_q : !m0_req;
  end

  // Tie-break pointer moves away from each new grant.
  always_comb begin
    prio_d = prio_q;
    if (state_q == StIdle && any_req) prio_d = !winner;
  end

  // Tie-break pointer register.
  always_ff @(posedge clk) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end
`else
  // Winner select: m0 wins whenever it requests.
  always_comb begin
    winner = !m0_req;
  end
`endif

  // Next-state: grant in idle, one RAM strobe, wait out read latency, ack.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          grant_d = winner;
          we_d    = winner ? m1_we    : m0_we;
          addr_d  = winner ? m1_addr  : m0_addr;
          wdata_d = winner ? m1_wdata : m0_wdata;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (we_q) begin
          state_d = StDone;
        end else begin
          state_d = StWait;
          cnt_d   = 2'(RD_LAT - 1);
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) begin
          if (grant_q) m1_rdata_d = ram_rdata;
          else         m0_rdata_d = ram_rdata;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= 2'd0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Outputs decode from registers only, so no req reaches the RAM or ack combinationally.
  always_comb begin
    ram_en    = (state_q == StAcc);
    ram_we    = (state_q == StAcc) && we_q;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    m0_ack    = (state_q == StDone) && !grant_q;
    m1_ack    = (state_q == StDone) && grant_q;
    m0_rdata  = m0_rdata_q;
    m1_rdata  = m1_rdata_q;
    busy      = (state_q != StIdle);
    grant_id  = grant_q;
  end

endmodule
